seq_pattern_detect: RTL and testbench
=====================================

# seq_pattern_detect

Parametrised state/sequence detector for the state-detection test suite. It samples a `IN_W`-bit input vector on enabled clock edges and keeps a `DEPTH`-deep history. It flags when the history matches a run-time-programmed, per-bit-masked pattern, and counts matches. It sits beside the DUT under test: on the DUT's stimulus/state bus, or any vector bus such as `{g3,g2,g1,g0}`. It generalises single-flop/fixed-circuit checking to arbitrary width, depth and match mode.

## Interface
- `IN_W`, 4, width of the sampled vector
- `DEPTH`, 4, pattern length in samples (≥1)
- `CNT_W`, 8, width of hit counter
- `CYC_W`, 16, width of cycle counter and first-hit stamp
- `IDX_W`, `$clog2(DEPTH)` (min 1), pattern index width
- `clk` in 1: single clock, rising edge
- `r` in 1: reset, asynchronous, active-low
- `en` in 1: capture `ins` this edge
- `ins` in `IN_W`: vector to monitor
- `clr` in 1: synchronous clear of history/counters (pattern kept)
- `mode` in 1: 0 = overlapping, 1 = non-overlapping
- `pat_ld` in 1: write pattern entry `pat_idx`
- `pat_idx` in `IDX_W`: entry index, 0 = first expected sample
- `pat_val` in `IN_W`: expected vector
- `pat_mask` in `IN_W`: 1 = compare bit, 0 = don't care
- `hit` out 1: one-cycle match pulse
- `hit_cnt` out `CNT_W`: saturating match count
- `first_vld` out 1: sticky, a hit has occurred
- `first_hit` out `CYC_W`: cycle stamp of first hit
- `cyc` out `CYC_W`: saturating clocks since reset/clr

## Operation
- Reset (`r`=0, immediate, no clock needed): history 0, fill count 0, `hit`=0, `hit_cnt`=0, `first_vld`=0, `first_hit`=0, `cyc`=0. Pattern values reset to 0, masks to all-ones.
- Default detection after reset is therefore `DEPTH` consecutive all-zero samples.
- History: shift register, `hist[DEPTH-1]` = most recent sample. On edge with `en`=1, shift in `ins`. Fill count increments, saturating at `DEPTH`.
- Candidate window = {hist[1..DEPTH-1], ins}.
- Match condition, at an edge with `en`=1: for every k, `(window[k] ^ pat_val[k]) & pat_mask[k]` == 0, and fill count ≥ `DEPTH-1` (the window is fully populated with samples).
- On match: `hit`←1 for one cycle. `hit_cnt`←`hit_cnt`+1, saturating at 2^CNT_W−1. If `first_vld`=0: `first_hit`←current `cyc` and `first_vld`←1.
- Mode 0 (overlapping): fill count unaffected by a hit.
- Mode 1 (non-overlapping): on hit, fill count←0, so the next hit needs `DEPTH` fresh samples.
- `hit`←0 on every edge without a match, including `en`=0 edges.
- `cyc` increments every edge regardless of `en`, saturating at 2^CYC_W−1.
- `pat_ld`: entry written at edge. The match at that same edge uses the old pattern.
- `clr`=1: history, fill count, `hit`, `hit_cnt`, `first_vld`, `first_hit` and `cyc` all go to 0. `clr` overrides `en` (sample discarded) and any match. A `pat_ld` in the same cycle still takes effect.
- Changing `mode` mid-run takes effect at the next edge. The fill count is not altered by the change itself.
- `pat_idx` ≥ `DEPTH`: write ignored.

## Timing
- All state registered on rising `clk`. Only `r` is asynchronous.
- `r` deassertion: first functional edge is the first rising edge after `r`=1.
- Latency: `hit` is high in the cycle following the edge that captured the completing sample. `hit_cnt` and `first_hit` update on that same edge.
- Maximum hit rate: one per enabled edge (mode 0), one per `DEPTH` enabled edges (mode 1).
- `en` gaps do not break a sequence. The history only advances on enabled edges.

## Test plan
- Async reset mid-run: after 3 hits, drive `r`=0 between edges → all outputs 0 immediately. After release, 4 zero samples (DEPTH=4) → `hit` pulse, `hit_cnt`=1.
- Counting stimulus: program pattern 1,2,3,4 (masks 4'hF). Drive `ins`=0,1,2,…,15 with `en`=1 from `cyc`=0 → exactly one `hit`, the cycle after the edge capturing 4. `first_hit`=4, `hit_cnt`=1.
- Overlap vs non-overlap: 8 consecutive zero samples with default pattern → mode 0 gives `hit_cnt`=5, mode 1 gives `hit_cnt`=2 (hits on samples 4 and 8).
- Mask: pattern masks 4'b0001, values 1 → any 4 odd samples match. Sequence 1,3,5,7 hits; 1,3,4,7 does not.
- Saturation: CNT_W=2, 6 overlapping hits → `hit_cnt` stays 3. `first_hit` keeps the first stamp.
- Simultaneous events: `clr` and `en` with a matching `ins` in the same cycle → no `hit`, all counters 0. `pat_ld` with a completing sample in the same cycle → match decided by the old entry.

Source files
------------

// File: rtl/seq_pattern_detect.sv
// seq_pattern_detect
//   Samples an IN_W-bit vector on enabled clock edges and keeps a DEPTH-deep
//   history. It flags each edge where the newest DEPTH samples match a
//   run-time programmed, per-bit masked pattern. It also counts matches,
//   stamps the cycle of the first match, and counts clocks.
//
// Ports
//   clk        rising-edge clock
//   r          asynchronous active-low reset
//   en         capture ins on this edge
//   ins        monitored vector
//   clr        synchronous clear of history/counters (pattern is kept)
//   mode       0 = overlapping matches, 1 = non-overlapping
//   pat_ld     write pattern entry pat_idx (pat_val, pat_mask)
//   pat_idx    entry index, 0 = oldest expected sample
//   pat_val    expected vector
//   pat_mask   1 = compare bit, 0 = don't care
//   hit        one-cycle match pulse
//   hit_cnt    saturating match count
//   first_vld  sticky, a match has occurred
//   first_hit  cyc value at the edge of the first match
//   cyc        saturating clocks since reset/clr
module seq_pattern_detect #(
  parameter int IN_W  = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8,
  parameter int CYC_W = 16,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             r,
  input  logic             en,
  input  logic [IN_W-1:0]  ins,
  input  logic             clr,
  input  logic             mode,
  input  logic             pat_ld,
  input  logic [IDX_W-1:0] pat_idx,
  input  logic [IN_W-1:0]  pat_val,
  input  logic [IN_W-1:0]  pat_mask,
  output logic             hit,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             first_vld,
  output logic [CYC_W-1:0] first_hit,
  output logic [CYC_W-1:0] cyc
);

  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] FILL_NEED = FILL_W'(DEPTH - 1);

  logic [IN_W-1:0]   r_hist [DEPTH];
  logic [IN_W-1:0]   r_pv   [DEPTH];
  logic [IN_W-1:0]   r_pm   [DEPTH];
  logic [FILL_W-1:0] r_fill;
  logic              r_hit;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic              r_first_vld;
  logic [CYC_W-1:0]  r_first_hit;
  logic [CYC_W-1:0]  r_cyc;

  logic [IN_W-1:0]   w_win [DEPTH];
  logic              w_cmp_ok;
  logic              w_match;
  logic              w_idx_ok;

  // Candidate window = {hist[1..DEPTH-1], ins}; it is also exactly the
  // history after an enabled shift, so it doubles as the shift input.
  for (genvar g = 0; g < DEPTH; g++) begin : g_win
    if (g < DEPTH - 1) begin : g_hist
      assign w_win[g] = r_hist[g+1];
    end else begin : g_new
      assign w_win[g] = ins;
    end
  end

  always_comb begin
    w_cmp_ok = 1'b1;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (((w_win[k] ^ r_pv[k]) & r_pm[k]) != '0) begin
        w_cmp_ok = 1'b0;
      end
    end
  end

  assign w_match  = en && !clr && (r_fill >= FILL_NEED) && w_cmp_ok;
  assign w_idx_ok = ({1'b0, pat_idx} < (IDX_W + 1)'(DEPTH));

  // Pattern store: unaffected by clr, so a load alongside clr still lands.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_pv[k] <= '0;
        r_pm[k] <= '1;
      end
    end else if (pat_ld && w_idx_ok) begin
      r_pv[pat_idx] <= pat_val;
      r_pm[pat_idx] <= pat_mask;
    end
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_hist[k] <= '0;
      end
      r_fill      <= '0;
      r_hit       <= 1'b0;
      r_hit_cnt   <= '0;
      r_first_vld <= 1'b0;
      r_first_hit <= '0;
      r_cyc       <= '0;
    end else if (clr) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_hist[k] <= '0;
      end
      r_fill      <= '0;
      r_hit       <= 1'b0;
      r_hit_cnt   <= '0;
      r_first_vld <= 1'b0;
      r_first_hit <= '0;
      r_cyc       <= '0;
    end else begin
      r_hit <= w_match;
      if (r_cyc != '1) begin
        r_cyc <= r_cyc + CYC_W'(1);
      end
      if (en) begin
        r_hist <= w_win;
        // Non-overlapping: a hit restarts the fill so DEPTH fresh samples
        // are needed before the next hit.
        if (w_match && mode) begin
          r_fill <= '0;
        end else if (r_fill != FILL_MAX) begin
          r_fill <= r_fill + FILL_W'(1);
        end
      end
      if (w_match) begin
        if (r_hit_cnt != '1) begin
          r_hit_cnt <= r_hit_cnt + CNT_W'(1);
        end
        if (!r_first_vld) begin
          r_first_vld <= 1'b1;
          r_first_hit <= r_cyc;
        end
      end
    end
  end

  assign hit       = r_hit;
  assign hit_cnt   = r_hit_cnt;
  assign first_vld = r_first_vld;
  assign first_hit = r_first_hit;
  assign cyc       = r_cyc;

endmodule

// File: tb/tb_seq_pattern_detect.sv
// Testbench for seq_pattern_detect: directed scenarios plus randomized
// stimulus, checked against a queue-based reference model. A second
// instance with a 2-bit hit counter shares all inputs to cover saturation.
module tb_seq_pattern_detect;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        r = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  ins = '0;
  logic        clr = 1'b0;
  logic        mode = 1'b0;
  logic        pat_ld = 1'b0;
  logic [1:0]  pat_idx = '0;
  logic [3:0]  pat_val = '0;
  logic [3:0]  pat_mask = '0;

  logic        hit, first_vld;
  logic [7:0]  hit_cnt;
  logic [15:0] first_hit, cyc;

  logic        s_hit, s_first_vld;
  logic [1:0]  s_hit_cnt;
  logic [15:0] s_first_hit, s_cyc;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [3:0] m_pv [DEPTH];
  logic [3:0] m_pm [DEPTH];
  logic [3:0] m_q [$];   // real samples since reset/clr, newest at back
  int         m_fresh;   // samples counted toward the next match
  bit         m_hit;
  int         m_cnt;     // unbounded match count
  bit         m_fv;
  int         m_fh;
  int         m_cyc;

  seq_pattern_detect #(.IN_W(4), .DEPTH(DEPTH), .CNT_W(8), .CYC_W(16)) u_dut (
    .clk(clk), .r(r), .en(en), .ins(ins), .clr(clr), .mode(mode),
    .pat_ld(pat_ld), .pat_idx(pat_idx), .pat_val(pat_val), .pat_mask(pat_mask),
    .hit(hit), .hit_cnt(hit_cnt), .first_vld(first_vld),
    .first_hit(first_hit), .cyc(cyc)
  );

  seq_pattern_detect #(.IN_W(4), .DEPTH(DEPTH), .CNT_W(2), .CYC_W(16)) u_sat (
    .clk(clk), .r(r), .en(en), .ins(ins), .clr(clr), .mode(mode),
    .pat_ld(pat_ld), .pat_idx(pat_idx), .pat_val(pat_val), .pat_mask(pat_mask),
    .hit(s_hit), .hit_cnt(s_hit_cnt), .first_vld(s_first_vld),
    .first_hit(s_first_hit), .cyc(s_cyc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) begin
      m_pv[k] = 4'h0;
      m_pm[k] = 4'hF;
    end
    m_q.delete();
    m_fresh = 0; m_hit = 0; m_cnt = 0; m_fv = 0; m_fh = 0; m_cyc = 0;
  endtask

  // Predicts the effect of the coming rising edge from the current inputs.
  task automatic model_edge();
    bit match;
    logic [3:0] s;
    if (clr) begin
      m_q.delete();
      m_fresh = 0; m_hit = 0; m_cnt = 0; m_fv = 0; m_fh = 0; m_cyc = 0;
    end else begin
      match = 0;
      if (en && m_fresh >= DEPTH - 1) begin
        match = 1;
        for (int k = 0; k < DEPTH; k++) begin
          if (k == DEPTH - 1) s = ins;
          else s = m_q[m_q.size() - (DEPTH - 1) + k];
          if (((s ^ m_pv[k]) & m_pm[k]) != 4'h0) match = 0;
        end
      end
      m_hit = match;
      if (match) begin
        m_cnt++;
        if (!m_fv) begin
          m_fv = 1;
          m_fh = m_cyc;
        end
      end
      if (en) begin
        m_q.push_back(ins);
        if (m_q.size() > DEPTH) void'(m_q.pop_front());
        if (match && mode) m_fresh = 0;
        else if (m_fresh < DEPTH) m_fresh++;
      end
      if (m_cyc < 65535) m_cyc++;
    end
    if (pat_ld && int'(pat_idx) < DEPTH) begin
      m_pv[pat_idx] = pat_val;
      m_pm[pat_idx] = pat_mask;
    end
  endtask

  task automatic check_all();
    chk("hit", hit, m_hit);
    chk("hit_cnt", hit_cnt, sat(m_cnt, 255));
    chk("sat_hit_cnt", s_hit_cnt, sat(m_cnt, 3));
    chk("first_vld", first_vld, m_fv);
    chk("first_hit", first_hit, m_fh);
    chk("cyc", cyc, m_cyc);
  endtask

  // Entered and left at a falling edge; control strobes drop afterwards.
  task automatic step(input logic e, input logic [3:0] d);
    en = e;
    ins = d;
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    en = 1'b0;
    clr = 1'b0;
    pat_ld = 1'b0;
  endtask

  task automatic feed(input int n, input logic [3:0] v);
    for (int i = 0; i < n; i++) step(1'b1, v);
  endtask

  // Loads all entries (entry i from nibble i), clearing on each load so
  // the run afterwards starts at cyc 0.
  task automatic set_pat(input logic [15:0] vals, input logic [15:0] masks);
    for (int i = 0; i < DEPTH; i++) begin
      pat_ld = 1'b1;
      pat_idx = 2'(i);
      pat_val = vals[4*i +: 4];
      pat_mask = masks[4*i +: 4];
      clr = 1'b1;
      step(1'b0, 4'h0);
    end
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_hit", hit, 0);
    chk("rst_cnt", hit_cnt, 0);
    chk("rst_fv", first_vld, 0);
    chk("rst_cyc", cyc, 0);
    @(negedge clk);
    r = 1'b1;

    // Default pattern: DEPTH consecutive zeros
    feed(4, 4'h0);
    chk("dflt_hit", hit, 1);

    // Counting stimulus against pattern 1,2,3,4
    mode = 1'b0;
    set_pat(16'h4321, 16'hFFFF);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 4'(i));
      if (i == 4) chk("count_pulse", hit, 1);
    end
    chk("count_first_hit", first_hit, 4);
    chk("count_hits", hit_cnt, 1);

    // Overlapping vs non-overlapping
    set_pat(16'h0000, 16'hFFFF);
    feed(8, 4'h0);
    chk("ovl_cnt", hit_cnt, 5);
    mode = 1'b1;
    set_pat(16'h0000, 16'hFFFF);
    feed(8, 4'h0);
    chk("novl_cnt", hit_cnt, 2);
    mode = 1'b0;

    // Masked pattern: LSB only
    set_pat(16'h1111, 16'h1111);
    step(1'b1, 4'd1); step(1'b1, 4'd3); step(1'b1, 4'd5); step(1'b1, 4'd7);
    chk("mask_hit", hit, 1);
    set_pat(16'h1111, 16'h1111);
    step(1'b1, 4'd1); step(1'b1, 4'd3); step(1'b1, 4'd4); step(1'b1, 4'd7);
    chk("mask_nohit", hit_cnt, 0);

    // Saturation with en gaps interleaved
    set_pat(16'h0000, 16'hFFFF);
    feed(2, 4'h0);
    step(1'b0, 4'h5);
    feed(7, 4'h0);
    chk("sat_cnt", s_hit_cnt, 3);
    chk("sat_wide_cnt", hit_cnt, 6);

    // pat_ld with completing sample: old entry decides
    set_pat(16'h4321, 16'hFFFF);
    feed(1, 4'd1); feed(1, 4'd2); feed(1, 4'd3);
    pat_ld = 1'b1; pat_idx = 2'd3; pat_val = 4'd9; pat_mask = 4'hF;
    step(1'b1, 4'd4);
    chk("pld_old", hit, 1);
    clr = 1'b1;
    step(1'b0, 4'h0);
    feed(1, 4'd1); feed(1, 4'd2); feed(1, 4'd3); feed(1, 4'd4);
    chk("pld_new", hit_cnt, 0);

    // clr with a completing sample
    clr = 1'b1;
    step(1'b0, 4'h0);
    feed(1, 4'd1); feed(1, 4'd2); feed(1, 4'd3);
    clr = 1'b1;
    step(1'b1, 4'd9);
    chk("clr_hit", hit, 0);
    chk("clr_cyc", cyc, 0);
    feed(1, 4'd9);
    chk("clr_discard", hit, 0);

    // Async reset mid-run after 3 hits
    set_pat(16'h0000, 16'hFFFF);
    feed(6, 4'h0);
    chk("pre_rst_cnt", hit_cnt, 3);
    #2;
    r = 1'b0;
    #1;
    model_reset();
    chk("arst_hit", hit, 0);
    chk("arst_cnt", hit_cnt, 0);
    chk("arst_fv", first_vld, 0);
    chk("arst_fh", first_hit, 0);
    chk("arst_cyc", cyc, 0);
    @(negedge clk);
    r = 1'b1;
    feed(4, 4'h0);
    chk("post_rst_hit", hit, 1);
    chk("post_rst_cnt", hit_cnt, 1);

    // Randomized run
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      clr = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 14) == 0) begin
        pat_ld = 1'b1;
        pat_idx = 2'($urandom_range(0, 3));
        pat_val = 4'($urandom_range(0, 3));
        pat_mask = 4'($urandom);
      end
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
